// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared types, tap constants and next-state functions for the
//                BIST controller (LFSR stimulus, MISR compaction).
//  Revision    : 1.0  initial release
// ============================================================================
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int C_LFSR_W = 14;
    localparam int C_MISR_W = 16;

    // Feedback taps: LFSR bits 13,4,2,0 ; MISR bits 15,14,12,3
    localparam logic [C_LFSR_W-1:0] C_LFSR_TAPS     = 14'h2015;
    localparam logic [C_MISR_W-1:0] C_MISR_TAPS     = 16'hD008;
    // Substituted for an all-zero seed, which would lock the LFSR
    localparam logic [C_LFSR_W-1:0] C_LFSR_SEED_DEF = 14'h0001;

    // Fibonacci shift-left, maximal length 2^14-1
    function automatic logic [C_LFSR_W-1:0] lfsr_next(input logic [C_LFSR_W-1:0] l);
        return {l[C_LFSR_W-2:0], ^(l & C_LFSR_TAPS)};
    endfunction

    // Shift with feedback, then fold in the (zero-extended) response vector
    function automatic logic [C_MISR_W-1:0] misr_next(input logic [C_MISR_W-1:0] m,
                                                      input logic [C_MISR_W-1:0] po);
        return {m[C_MISR_W-2:0], ^(m & C_MISR_TAPS)} ^ po;
    endfunction

endpackage : bist_pkg
`default_nettype wire

// File: rtl/dut_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dut_bist_ctrl_if
//  Description : Host-side control/result bundle plus the netlist stimulus and
//                response vectors of the BIST controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface dut_bist_ctrl_if #(
    parameter int PI_W       = 14,
    parameter int PO_W       = 8,
    parameter int SIG_W      = 16,
    parameter int N_PATTERNS = 256
);
    localparam int CNT_W = $clog2(N_PATTERNS + 1);

    logic             start;
    logic [PI_W-1:0]  seed_i;
    logic [SIG_W-1:0] golden_i;
    logic [PI_W-1:0]  pi_o;
    logic [PO_W-1:0]  po_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [SIG_W-1:0] signature_o;
    logic [CNT_W-1:0] pat_cnt_o;

    // Host / netlist side
    modport master (
        output start, seed_i, golden_i, po_i,
        input  pi_o, busy_o, done_o, pass_o, signature_o, pat_cnt_o
    );

    // BIST controller side
    modport slave (
        input  start, seed_i, golden_i, po_i,
        output pi_o, busy_o, done_o, pass_o, signature_o, pat_cnt_o
    );

endinterface : dut_bist_ctrl_if
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
//  Module      : bist_misr
//  Description : Multiple-input signature register compacting netlist
//                responses; synchronous clear, capture on enable.
//  Revision    : 1.0  initial release
// ============================================================================
module bist_misr
    import bist_pkg::*;
#(
    parameter int SIG_W = 16,
    parameter int PO_W  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [PO_W-1:0]  po,
    output logic      [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;

    // Signature register: clear has priority over capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= misr_next(r_sig, C_MISR_W'(po));
        end
    end

    assign sig = r_sig;

endmodule : bist_misr
`default_nettype wire

// File: rtl/dut_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dut_bist_ctrl
//  Description : BIST controller: drives a combinational netlist with LFSR
//                patterns, compacts its responses in a MISR and compares the
//                final signature against a golden value.
//  Revision    : 1.0  initial release
// ============================================================================
module dut_bist_ctrl
    import bist_pkg::*;
#(
    parameter int PI_W       = 14,   // LFSR taps are fixed for 14 bits
    parameter int PO_W       = 8,    // at most SIG_W
    parameter int N_PATTERNS = 256,  // at least 1
    parameter int SETTLE_CYC = 1,
    parameter int SIG_W      = 16    // MISR taps are fixed for 16 bits
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dut_bist_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(N_PATTERNS + 1);
    localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PI_W-1:0]  r_lfsr;
    logic [SET_W-1:0] r_settle;
    logic [CNT_W-1:0] r_pat_cnt;
    logic [SIG_W-1:0] r_golden;
    logic [SIG_W-1:0] r_signature;
    logic             r_pass;
    logic             r_done;
    logic             r_busy;
    logic [SIG_W-1:0] w_misr;
    logic             w_start_acc;
    logic             w_capture;
    logic             w_last;

    assign w_start_acc = (r_state == IDLE) && bus.start;
    assign w_capture   = (r_state == DRIVE) && (r_settle == SET_W'(SETTLE_CYC));
    assign w_last      = w_capture && (r_pat_cnt == CNT_W'(N_PATTERNS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only honoured from IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = DRIVE;
            DRIVE:   if (w_last)    w_state_nxt = FINISH;
            FINISH:                 w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Stimulus LFSR: seeded on start (zero seed replaced), stepped per capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= '0;
        end else if (w_start_acc) begin
            r_lfsr <= (bus.seed_i == '0) ? C_LFSR_SEED_DEF : bus.seed_i;
        end else if (w_capture) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Settle counter: holds each pattern for SETTLE_CYC+1 cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= '0;
        end else if (w_start_acc || w_capture) begin
            r_settle <= '0;
        end else if (r_state == DRIVE) begin
            r_settle <= r_settle + SET_W'(1);
        end
    end

    // Pattern counter: stops at N_PATTERNS since captures end with the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat_cnt <= '0;
        end else if (w_start_acc) begin
            r_pat_cnt <= '0;
        end else if (w_capture) begin
            r_pat_cnt <= r_pat_cnt + CNT_W'(1);
        end
    end

    // Run status and results; done is a registered one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_golden    <= '0;
            r_signature <= '0;
            r_pass      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= (r_state == FINISH);
            if (w_start_acc) begin
                r_golden <= bus.golden_i;
                r_pass   <= 1'b0;
                r_busy   <= 1'b1;
            end else if (r_state == FINISH) begin
                r_signature <= w_misr;
                r_pass      <= (w_misr == r_golden);
                r_busy      <= 1'b0;
            end
        end
    end

    bist_misr #(
        .SIG_W (SIG_W),
        .PO_W  (PO_W)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (w_start_acc),
        .en  (w_capture),
        .po  (bus.po_i),
        .sig (w_misr)
    );

    assign bus.pi_o        = r_lfsr;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.pass_o      = r_pass;
    assign bus.signature_o = r_signature;
    assign bus.pat_cnt_o   = r_pat_cnt;

endmodule : dut_bist_ctrl
`default_nettype wire

// File: tb/tb_dut_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dut_bist_ctrl
//  Description : Directed self-checking bench; three controller instances
//                cover N=1/S=0, N=2/S=0 and N=4/S=2 configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dut_bist_ctrl;
    import bist_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dut_bist_ctrl_if #(.PI_W(14), .PO_W(8), .SIG_W(16), .N_PATTERNS(1)) bus_a ();
    dut_bist_ctrl_if #(.PI_W(14), .PO_W(8), .SIG_W(16), .N_PATTERNS(2)) bus_b ();
    dut_bist_ctrl_if #(.PI_W(14), .PO_W(8), .SIG_W(16), .N_PATTERNS(4)) bus_c ();

    dut_bist_ctrl #(.PI_W(14), .PO_W(8), .N_PATTERNS(1), .SETTLE_CYC(0), .SIG_W(16))
        u_a (.clk(clk), .rst(rst), .bus(bus_a));
    dut_bist_ctrl #(.PI_W(14), .PO_W(8), .N_PATTERNS(2), .SETTLE_CYC(0), .SIG_W(16))
        u_b (.clk(clk), .rst(rst), .bus(bus_b));
    dut_bist_ctrl #(.PI_W(14), .PO_W(8), .N_PATTERNS(4), .SETTLE_CYC(2), .SIG_W(16))
        u_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Registered "netlist" for instance C
    function automatic logic [7:0] resp_fn(input logic [13:0] p);
        return p[7:0] ^ p[13:6] ^ 8'h3C;
    endfunction

    always @(posedge clk) bus_c.po_i <= resp_fn(bus_c.pi_o);

    function automatic logic [15:0] model_c(input logic [13:0] seed, input int n);
        logic [13:0] l;
        logic [15:0] m;
        l = (seed == 14'h0) ? 14'h0001 : seed;
        m = '0;
        for (int i = 0; i < n; i++) begin
            m = misr_next(m, 16'(resp_fn(l)));
            l = lfsr_next(l);
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on instance C; returns cycles elapsed or -1 on timeout
    task automatic wait_done_c(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus_c.done_o) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        logic [13:0] l;
        logic [15:0] gold_c;
        logic [15:0] gold_c2;
        int          period;
        bit          hit0;
        int          cyc;

        bus_a.start = 0; bus_a.seed_i = '0; bus_a.golden_i = '0; bus_a.po_i = 8'hA5;
        bus_b.start = 0; bus_b.seed_i = '0; bus_b.golden_i = '0; bus_b.po_i = 8'hA5;
        bus_c.start = 0; bus_c.seed_i = '0; bus_c.golden_i = '0;

        // ---------------- reset state
        #12;
        check("rst_pi",   32'(bus_a.pi_o),        32'h0);
        check("rst_busy", 32'(bus_a.busy_o),      32'h0);
        check("rst_done", 32'(bus_c.done_o),      32'h0);
        check("rst_pass", 32'(bus_c.pass_o),      32'h0);
        check("rst_sig",  32'(bus_c.signature_o), 32'h0);
        check("rst_cnt",  32'(bus_c.pat_cnt_o),   32'h0);
        rst = 0;
        step();

        // ---------------- A: N=1, S=0, seed 1, po A5, golden 00A5
        bus_a.seed_i = 14'h0001; bus_a.golden_i = 16'h00A5; bus_a.start = 1;
        step();                       // start edge
        bus_a.start = 0;
        check("a_pi_first", 32'(bus_a.pi_o),   32'h0001);
        check("a_busy",     32'(bus_a.busy_o), 32'h1);
        step();                       // capture edge
        check("a_done_early", 32'(bus_a.done_o),    32'h0);
        check("a_cnt",        32'(bus_a.pat_cnt_o), 32'h1);
        step();                       // 2 cycles after start
        check("a_done",   32'(bus_a.done_o),      32'h1);
        check("a_sig",    32'(bus_a.signature_o), 32'h00A5);
        check("a_pass",   32'(bus_a.pass_o),      32'h1);
        check("a_idle",   32'(bus_a.busy_o),      32'h0);
        check("a_pi_adv", 32'(bus_a.pi_o),        32'h0003);
        step();
        check("a_done_pulse", 32'(bus_a.done_o), 32'h0);

        // ---------------- B: N=2, S=0, seed 1, po A5, golden 0
        bus_b.seed_i = 14'h0001; bus_b.golden_i = 16'h0000; bus_b.start = 1;
        step();
        bus_b.start = 0;
        check("b_pi0", 32'(bus_b.pi_o), 32'h0001);
        step();
        check("b_pi1", 32'(bus_b.pi_o), 32'h0003);
        step();
        step();
        check("b_done", 32'(bus_b.done_o),      32'h1);
        check("b_sig",  32'(bus_b.signature_o), 32'h01EF);
        check("b_pass", 32'(bus_b.pass_o),      32'h0);
        check("b_cnt",  32'(bus_b.pat_cnt_o),   32'h2);

        // ---------------- B: zero seed falls back to 0x0001
        bus_b.seed_i = 14'h0000; bus_b.golden_i = 16'h01EF; bus_b.start = 1;
        step();
        bus_b.start = 0;
        check("b_zero_seed", 32'(bus_b.pi_o), 32'h0001);
        cyc = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus_b.done_o) begin cyc = k; break; end
        end
        check("b_zero_lat",  32'(cyc),               32'd3);
        check("b_zero_sig",  32'(bus_b.signature_o), 32'h01EF);
        check("b_zero_pass", 32'(bus_b.pass_o),      32'h1);
        step(); step(); step();
        check("b_cnt_hold",  32'(bus_b.pat_cnt_o),   32'h2);

        // ---------------- LFSR period through the shared step function
        l = 14'h0001; period = 0; hit0 = 0;
        for (int i = 1; i <= 16383; i++) begin
            l = lfsr_next(l);
            if (l == 14'h0) hit0 = 1;
            if (l == 14'h0001 && period == 0) period = i;
        end
        check("lfsr_period", 32'(period), 32'd16383);
        check("lfsr_nozero", 32'(hit0),   32'd0);

        // ---------------- C: N=4, S=2, with start pulses mid-run and in FINISH
        gold_c  = model_c(14'h1234, 4);
        gold_c2 = model_c(14'h0ABC, 4);
        bus_c.seed_i = 14'h1234; bus_c.golden_i = gold_c; bus_c.start = 1;
        step();
        bus_c.start = 0;
        check("c_pi0", 32'(bus_c.pi_o), 32'h1234);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1 || k == 2) check("c_hold", 32'(bus_c.pi_o), 32'h1234);
            if (k == 3) check("c_adv", 32'(bus_c.pi_o), 32'(lfsr_next(14'h1234)));
            if (k == 5) begin bus_c.start = 1; bus_c.seed_i = 14'h0ABC; end
            if (k == 6) bus_c.start = 0;
            if (k == 12) bus_c.start = 1;    // lands on the FINISH edge
            if (bus_c.done_o) begin cyc = k; break; end
        end
        check("c_latency", 32'(cyc),               32'd13);
        check("c_sig",     32'(bus_c.signature_o), 32'(gold_c));
        check("c_pass",    32'(bus_c.pass_o),      32'h1);
        check("c_busy_fin", 32'(bus_c.busy_o),     32'h0);
        step();                        // start still high, now in IDLE
        bus_c.start = 0;
        check("c_restart_busy", 32'(bus_c.busy_o), 32'h1);
        check("c_restart_pi",   32'(bus_c.pi_o),   32'h0ABC);
        check("c_restart_done", 32'(bus_c.done_o), 32'h0);
        wait_done_c(cyc);
        check("c2_latency", 32'(cyc),               32'd13);
        check("c2_sig",     32'(bus_c.signature_o), 32'(gold_c2));
        check("c2_pass",    32'(bus_c.pass_o),      32'((gold_c2 == gold_c) ? 1 : 0));

        // ---------------- C: asynchronous reset mid-DRIVE, then rerun
        bus_c.seed_i = 14'h1234; bus_c.golden_i = gold_c; bus_c.start = 1;
        step();
        bus_c.start = 0;
        for (int k = 1; k <= 10; k++) step();
        check("c_cnt_mid", 32'(bus_c.pat_cnt_o), 32'h3);
        #2 rst = 1;
        #1;
        check("ar_pi",   32'(bus_c.pi_o),        32'h0);
        check("ar_busy", 32'(bus_c.busy_o),      32'h0);
        check("ar_sig",  32'(bus_c.signature_o), 32'h0);
        check("ar_cnt",  32'(bus_c.pat_cnt_o),   32'h0);
        check("ar_pass", 32'(bus_c.pass_o),      32'h0);
        #2 rst = 0;
        step();
        bus_c.start = 1;
        step();
        bus_c.start = 0;
        wait_done_c(cyc);
        check("c3_latency", 32'(cyc),               32'd13);
        check("c3_sig",     32'(bus_c.signature_o), 32'(gold_c));
        check("c3_pass",    32'(bus_c.pass_o),      32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dut_bist_ctrl
`default_nettype wire

// File: doc/dut_bist_ctrl.md
Name: dut_bist_ctrl

Overview:
- Built-in self-test controller for the other end of a mapped combinational netlist's port interface.
- Drives the netlist's primary inputs with LFSR pseudo-random vectors and compacts its primary outputs into a MISR signature.
- Compares the signature to a golden value, so pre- and post-optimization netlists can be checked for equivalence in silicon or emulation.
- Sits beside the DUT netlist: pi_o feeds the netlist inputs, and the netlist outputs return on po_i.

Parameters:
- PI_W, 14, width of stimulus vector (netlist primary inputs)
- PO_W, 8, width of response vector (netlist primary outputs), must be ≤ 16
- N_PATTERNS, 256, patterns per run, must be ≥ 1
- SETTLE_CYC, 1, extra cycles each pattern is held before po_i is sampled, must be ≥ 0
- SIG_W, 16, MISR width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; begin a run (honoured in IDLE only)
- seed_i  in  PI_W  LFSR seed, sampled on accepted start
- golden_i  in  SIG_W  expected signature, sampled on accepted start
- pi_o  out  PI_W  stimulus to netlist
- po_i  in  PO_W  response from netlist
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse at run completion
- pass_o  out  1  signature == golden, valid after done
- signature_o  out  SIG_W  final MISR value, held until next start
- pat_cnt_o  out  clog2(N_PATTERNS+1)  patterns captured so far

Behaviour:
- Reset (async, any state): state IDLE; pi_o=0, busy_o=0, done_o=0, pass_o=0, signature_o=0, pat_cnt_o=0. An aborted run leaves no partial results.
- IDLE, start=1 accepted on an edge:
  - LFSR <= seed_i, or 14'h0001 if seed_i==0 (the all-zero lock-up is forbidden).
  - MISR <= 0, pat_cnt <= 0, golden latched, pass_o <= 0, busy_o <= 1.
  - Next state DRIVE.
- pi_o is the LFSR register at all times outside reset.
- DRIVE: hold the pattern; a settle counter counts 0..SETTLE_CYC. On the edge where the counter == SETTLE_CYC:
  - MISR <= misr_next(MISR, po_i), pat_cnt++, LFSR <= lfsr_next(LFSR), settle counter cleared.
  - If pat_cnt reaches N_PATTERNS, go to FINISH.
  - Each pattern is therefore presented for SETTLE_CYC+1 cycles.
- FINISH (one cycle):
  - signature_o <= MISR, pass_o <= (MISR==golden), done_o=1, busy_o <= 0.
  - Next state IDLE.
  - pi_o holds the already-advanced next vector.
- lfsr_next: Fibonacci shift-left, fb = l[13]^l[4]^l[2]^l[0], next = {l[12:0], fb}. Maximal length 2^14-1.
- misr_next: fb = m[15]^m[14]^m[12]^m[3], next = {m[14:0], fb} ^ zero-extended po_i.
- start while busy (DRIVE/FINISH): ignored, no restart.
- start in the same cycle as FINISH: ignored; it is accepted only in IDLE.
- N_PATTERNS=1: exactly one capture, then FINISH.
- SETTLE_CYC=0: one pattern per cycle.
- Total run latency from the start edge to the done_o cycle: N_PATTERNS*(SETTLE_CYC+1)+1 cycles.
- pat_cnt_o saturates at N_PATTERNS and holds after done.

Decomposition:
- Shared package bist_pkg:
  - state enum {IDLE, DRIVE, FINISH}
  - LFSR and MISR tap constants
  - pure functions lfsr_next and misr_next, reused by the bench model
- One natural sub-module: bist_misr (SIG_W register, clear, enable, po input, misr_next update).
- LFSR, FSM and counters stay in the top.

Test Plan:
- N_PATTERNS=1, SETTLE_CYC=0, seed 0x0001, po_i tied 0xA5, golden 0x00A5 -> pi_o=0x0001 during capture, signature_o=0x00A5, pass_o=1, done_o pulses 2 cycles after the start edge.
- N_PATTERNS=2, SETTLE_CYC=0, seed 0x0001, po_i tied 0xA5, golden 0x0000:
  - pi_o sequence is 0x0001 then 0x0003.
  - signature_o=0x01EF, pass_o=0, pat_cnt_o=2.
- seed_i=0 -> first pi_o=0x0001 (lock-up avoided); LFSR period check over 16383 steps returns to seed, never hits 0.
- SETTLE_CYC=2, N_PATTERNS=4, po_i = registered function of pi_o:
  - each vector held 3 cycles.
  - done_o at cycle 13 after start.
  - signature matches the bench model built from bist_pkg functions.
- start pulsed mid-run and again during FINISH -> ignored; run result unchanged; start next cycle in IDLE accepted.
- rst asserted mid-DRIVE (pat_cnt=3) -> all outputs 0 immediately (asynchronously); fresh start after release gives the same signature as an uninterrupted run.
